mips_program_loader: RTL

- Front-end stage ahead of the pipelined MIPS core.
- Accepts a word-serial program stream over a valid/ready handshake and writes it into instruction memory from address 0.
- Fills the unused tail of memory with NOPs, then asserts start_program.
- Supervises the run until the core signals halt or a cycle budget expires, reporting completion status to the bench.

---
 rtl/mips_program_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mips_program_loader.sv
// Program loader ahead of the MIPS core: streams a program into instruction
// memory, pads the tail with NOPs, then starts and supervises the run.
module mips_program_loader #(
    parameter int          IMEM_DEPTH = 1024,
    parameter int          ADDR_W     = 10,
    parameter int          MAX_CYCLES = 10000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              halt_in,
    output logic              start_program,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   prog_len,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [31:0]       LAST_CYCLE = 32'(MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              timeout_q, timeout_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    // Set when the stream itself reached the last address, so FILL has nothing to write.
    logic              full_q, full_d;

    logic handshake;
    logic fill_wr;

    assign handshake = (state_q == S_LOAD) && word_valid;
    assign fill_wr   = (state_q == S_FILL) && !full_q;

    assign word_ready    = (state_q == S_LOAD);
    assign imem_we       = handshake || fill_wr;
    assign imem_addr     = addr_q;
    assign imem_wdata    = handshake ? word_data : (fill_wr ? NOP_WORD : 32'h0);
    assign start_program = start_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign prog_len      = prog_len_q;
    assign cycle_count   = cycle_count_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        prog_len_d    = prog_len_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        done_d        = done_q;
        start_d       = start_q;
        full_d        = full_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_req) begin
                    state_d       = S_LOAD;
                    addr_d        = '0;
                    prog_len_d    = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                    done_d        = 1'b0;
                    start_d       = 1'b0;
                    full_d        = 1'b0;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    prog_len_d = prog_len_q + 1'b1;
                    // Saturate at the top of memory instead of wrapping.
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_FILL;
                        full_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (word_last) state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (!full_q) addr_d = addr_q + 1'b1;
                if (full_q || addr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                // Halt takes priority over budget expiry; the count freezes on exit.
                if (halt_in) begin
                    state_d   = S_DONE;
                    start_d   = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (cycle_count_q == LAST_CYCLE) begin
                    state_d   = S_DONE;
                    start_d   = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            prog_len_q    <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            prog_len_q    <= prog_len_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
            start_q       <= start_d;
            full_q        <= full_d;
        end
    end

endmodule
